// File: rtl/region_attr_sender.sv
`default_nettype none
// =============================================================================
// region_attr_sender: walks every page of every bank and emits one resolved
// region attribute per page. Optional REGION_ATTR_SENDER_PARITY_EN adds attr_par_o.
// Revision: 1.0
// =============================================================================
module region_attr_sender #(
    parameter int NumBanks     = 2,
    parameter int PagesPerBank = 64,
    parameter int NumRegions   = 4,
    localparam int TotPages    = NumBanks * PagesPerBank,
    localparam int PW          = $clog2(TotPages),
    localparam int IW          = (NumRegions > 1) ? $clog2(NumRegions) : 1,
    localparam int BW          = (NumBanks > 1) ? $clog2(NumBanks) : 1,
    localparam int PGW         = (PagesPerBank > 1) ? $clog2(PagesPerBank) : 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           cfg_we_i,
    input  logic [IW-1:0]  cfg_idx_i,
    input  logic [PW-1:0]  cfg_base_i,
    input  logic [PW:0]    cfg_size_i,
    input  logic [1:0]     cfg_phase_i,
    input  logic [3:0]     cfg_en_i,
    output logic           cfg_err_o,
    input  logic           start_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           attr_valid_o,
    input  logic           attr_ready_i,
    output logic [5:0]     attr_o,
`ifdef REGION_ATTR_SENDER_PARITY_EN
    output logic           attr_par_o,
`endif
    output logic [BW-1:0]  bank_o,
    output logic [PGW-1:0] page_o
);

    localparam logic [1:0]     PH_NONE      = 2'b10;
    localparam logic [3:0]     EN_TRUE      = 4'h6;
    localparam logic [3:0]     EN_FALSE     = 4'h9;
    localparam logic [5:0]     DEFAULT_ATTR = {PH_NONE, EN_FALSE};
    localparam logic [BW-1:0]  LAST_BANK    = BW'(NumBanks - 1);
    localparam logic [PGW-1:0] LAST_PAGE    = PGW'(PagesPerBank - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e         state_q;
    logic           valid_q;
    logic           done_q;
    logic           err_q;
    logic [5:0]     attr_q;
    logic [BW-1:0]  bank_q;
    logic [PGW-1:0] page_q;

    logic [PW-1:0]  base_q  [NumRegions];
    logic [PW:0]    size_q  [NumRegions];
    logic [1:0]     phase_q [NumRegions];
    logic [3:0]     en_q    [NumRegions];
    logic [PW-1:0]  base_d  [NumRegions];
    logic [PW:0]    size_d  [NumRegions];
    logic [1:0]     phase_d [NumRegions];
    logic [3:0]     en_d    [NumRegions];

    logic           busy;
    logic           en_legal;
    logic           wr_ok;
    logic           fire;
    logic           last;
    logic           load;
    logic [BW-1:0]  bank_d;
    logic [PGW-1:0] page_d;
    logic [PW:0]    gpage_d;
    logic [5:0]     attr_d;

    assign busy     = (state_q != IDLE);
    assign en_legal = (cfg_en_i == EN_TRUE) || (cfg_en_i == EN_FALSE);
    assign wr_ok    = cfg_we_i && !busy;
    assign fire     = valid_q && attr_ready_i;
    assign last     = (bank_q == LAST_BANK) && (page_q == LAST_PAGE);

    // Next table contents; resolution uses these so a write alongside start_i is seen
    always_comb begin
        for (int i = 0; i < NumRegions; i++) begin
            base_d[i]  = base_q[i];
            size_d[i]  = size_q[i];
            phase_d[i] = phase_q[i];
            en_d[i]    = en_q[i];
        end
        if (wr_ok) begin
            base_d[cfg_idx_i]  = cfg_base_i;
            size_d[cfg_idx_i]  = cfg_size_i;
            phase_d[cfg_idx_i] = cfg_phase_i;
            en_d[cfg_idx_i]    = en_legal ? cfg_en_i : EN_FALSE;
        end
    end

    always_comb begin
        load   = 1'b0;
        bank_d = bank_q;
        page_d = page_q;
        if (state_q == IDLE && start_i) begin
            load   = 1'b1;
            bank_d = '0;
            page_d = '0;
        end else if (state_q == SEND && fire && !last) begin
            load = 1'b1;
            if (page_q == LAST_PAGE) begin
                page_d = '0;
                bank_d = bank_q + 1'b1;
            end else begin
                page_d = page_q + 1'b1;
            end
        end
    end

    assign gpage_d = (PW+1)'(bank_d) * (PW+1)'(PagesPerBank) + (PW+1)'(page_d);

    // Highest index evaluated first so the lowest matching index wins; the
    // subtraction form keeps the upper-bound test exact without any wrap.
    always_comb begin
        attr_d = DEFAULT_ATTR;
        for (int i = NumRegions - 1; i >= 0; i--) begin
            if (size_d[i] != '0 && gpage_d >= {1'b0, base_d[i]} &&
                (gpage_d - {1'b0, base_d[i]}) < size_d[i]) begin
                attr_d = {phase_d[i], en_d[i]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumRegions; i++) begin
                base_q[i]  <= '0;
                size_q[i]  <= '0;
                phase_q[i] <= PH_NONE;
                en_q[i]    <= EN_FALSE;
            end
        end else begin
            for (int i = 0; i < NumRegions; i++) begin
                base_q[i]  <= base_d[i];
                size_q[i]  <= size_d[i];
                phase_q[i] <= phase_d[i];
                en_q[i]    <= en_d[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            attr_q  <= DEFAULT_ATTR;
            bank_q  <= '0;
            page_q  <= '0;
        end else begin
            err_q  <= cfg_we_i && (busy || !en_legal);
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= SEND;
                        valid_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (fire && last) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
            if (load) begin
                attr_q <= attr_d;
                bank_q <= bank_d;
                page_q <= page_d;
            end
        end
    end

`ifdef REGION_ATTR_SENDER_PARITY_EN
    logic par_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_q <= ~^DEFAULT_ATTR;
        end else if (load) begin
            par_q <= ~^attr_d;
        end
    end

    assign attr_par_o = par_q;
`else
`endif

    assign cfg_err_o    = err_q;
    assign busy_o       = busy;
    assign done_o       = done_q;
    assign attr_valid_o = valid_q;
    assign attr_o       = attr_q;
    assign bank_o       = bank_q;
    assign page_o       = page_q;

endmodule
`default_nettype wire

// File: tb/tb_region_attr_sender.sv
`default_nettype none
// =============================================================================
// tb_region_attr_sender: random walks scored against a page-table reference model.
// Revision: 1.0
// =============================================================================
module tb_region_attr_sender;

    localparam int NB  = 2;
    localparam int PPB = 64;
    localparam int NR  = 4;
    localparam int TOT = NB * PPB;

    localparam logic [1:0] PH_SEED  = 2'b00;
    localparam logic [1:0] PH_RMA   = 2'b01;
    localparam logic [1:0] PH_NONE  = 2'b10;
    localparam logic [1:0] PH_INV   = 2'b11;
    localparam logic [3:0] EN_TRUE  = 4'h6;
    localparam logic [3:0] EN_FALSE = 4'h9;
    localparam logic [5:0] DEF_ATTR = 6'b10_1001;

    logic       clk_i        = 1'b0;
    logic       rst_ni       = 1'b0;
    logic       cfg_we_i     = 1'b0;
    logic [1:0] cfg_idx_i    = '0;
    logic [6:0] cfg_base_i   = '0;
    logic [7:0] cfg_size_i   = '0;
    logic [1:0] cfg_phase_i  = '0;
    logic [3:0] cfg_en_i     = '0;
    logic       start_i      = 1'b0;
    logic       attr_ready_i = 1'b0;
    logic       cfg_err_o;
    logic       busy_o;
    logic       done_o;
    logic       attr_valid_o;
    logic [5:0] attr_o;
    logic       bank_o;
    logic [5:0] page_o;
`ifdef REGION_ATTR_SENDER_PARITY_EN
    logic       attr_par_o;
`endif

    region_attr_sender dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cfg_we_i     (cfg_we_i),
        .cfg_idx_i    (cfg_idx_i),
        .cfg_base_i   (cfg_base_i),
        .cfg_size_i   (cfg_size_i),
        .cfg_phase_i  (cfg_phase_i),
        .cfg_en_i     (cfg_en_i),
        .cfg_err_o    (cfg_err_o),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .attr_valid_o (attr_valid_o),
        .attr_ready_i (attr_ready_i),
        .attr_o       (attr_o),
`ifdef REGION_ATTR_SENDER_PARITY_EN
        .attr_par_o   (attr_par_o),
`endif
        .bank_o       (bank_o),
        .page_o       (page_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [5:0] attr;
        logic       bank;
        logic [5:0] page;
    } beat_t;

    beat_t      expq[$];
    int         n_chk   = 0;
    int         n_pass  = 0;
    bit         walking = 0;
    int         rdy_mode = 0;
    bit         stall_done = 0;

    int         m_base [NR];
    int         m_size [NR];
    logic [1:0] m_ph   [NR];
    logic [3:0] m_en   [NR];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [5:0] resolve(input int g);
        for (int i = 0; i < NR; i++)
            if (m_size[i] != 0 && g >= m_base[i] && g < m_base[i] + m_size[i])
                return {m_ph[i], m_en[i]};
        return DEF_ATTR;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_base[i] = 0; m_size[i] = 0; m_ph[i] = PH_NONE; m_en[i] = EN_FALSE;
        end
    endtask

    task automatic model_write(input int idx, input int base, input int size,
                               input logic [1:0] ph, input logic [3:0] en);
        if (!walking) begin
            m_base[idx] = base;
            m_size[idx] = size;
            m_ph[idx]   = ph;
            m_en[idx]   = (en == EN_TRUE || en == EN_FALSE) ? en : EN_FALSE;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drive_cfg(input int idx, input int base, input int size,
                             input logic [1:0] ph, input logic [3:0] en);
        cfg_we_i    = 1'b1;
        cfg_idx_i   = 2'(idx);
        cfg_base_i  = 7'(base);
        cfg_size_i  = 8'(size);
        cfg_phase_i = ph;
        cfg_en_i    = en;
        model_write(idx, base, size, ph, en);
    endtask

    task automatic cfg_write(input int idx, input int base, input int size,
                             input logic [1:0] ph, input logic [3:0] en);
        bit exp_err;
        exp_err = walking || !(en == EN_TRUE || en == EN_FALSE);
        drive_cfg(idx, base, size, ph, en);
        cyc(1);
        cfg_we_i = 1'b0;
        chk("cfg_err_pulse", 32'(cfg_err_o), 32'(exp_err));
        cyc(1);
        chk("cfg_err_clear", 32'(cfg_err_o), 32'(0));
    endtask

    task automatic start_walk();
        beat_t b;
        start_i = 1'b1;
        for (int g = 0; g < TOT; g++) begin
            b.attr = resolve(g);
            b.bank = 1'(g / PPB);
            b.page = 6'(g % PPB);
            expq.push_back(b);
        end
        cyc(1);
        start_i = 1'b0;
        walking = 1'b1;
        chk("busy_on_start", 32'(busy_o), 32'(1));
        chk("first_valid", 32'(attr_valid_o), 32'(1));
        chk("first_bankpage", 32'({bank_o, page_o}), 32'(0));
        chk("first_attr", 32'(attr_o), 32'(resolve(0)));
    endtask

    task automatic wait_done();
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (n < 4000 && !seen) begin
            @(negedge clk_i);
            if (done_o) seen = 1;
            n++;
        end
        chk("walk_done_seen", 32'(seen), 32'(1));
        chk("queue_drained", 32'(expq.size()), 32'(0));
        chk("busy_in_done", 32'(busy_o), 32'(1));
        chk("valid_in_done", 32'(attr_valid_o), 32'(0));
        walking = 1'b0;
        cyc(1);
        chk("busy_after_done", 32'(busy_o), 32'(0));
        chk("done_one_cycle", 32'(done_o), 32'(0));
    endtask

    task automatic run_walk();
        start_walk();
        wait_done();
    endtask

    task automatic chk_reset_vals();
        chk("rst_attr", 32'(attr_o), 32'(DEF_ATTR));
        chk("rst_valid", 32'(attr_valid_o), 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_done", 32'(done_o), 32'(0));
        chk("rst_err", 32'(cfg_err_o), 32'(0));
        chk("rst_bankpage", 32'({bank_o, page_o}), 32'(0));
`ifdef REGION_ATTR_SENDER_PARITY_EN
        chk("rst_par", 32'(attr_par_o), 32'(~^DEF_ATTR));
`endif
    endtask

    // Monitor: scoreboard pops on every accepted beat, plus done/stall tracking
    initial begin
        beat_t e;
        beat_t held_b;
        bit    last_fired;
        bit    held;
        last_fired = 0;
        held = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                last_fired = 0;
                held = 0;
            end else begin
                chk("done_o", 32'(done_o), 32'(last_fired));
                last_fired = 0;
                if (held) begin
                    chk("stall_valid", 32'(attr_valid_o), 32'(1));
                    chk("stall_beat", 32'({attr_o, bank_o, page_o}), 32'(held_b));
                end
                held = 0;
                if (attr_valid_o && !attr_ready_i) begin
                    held = 1;
                    held_b = {attr_o, bank_o, page_o};
                end
                if (attr_valid_o && attr_ready_i) begin
                    if (expq.size() == 0) begin
                        chk("beat_expected", 32'(expq.size()), 32'(1));
                    end else begin
                        e = expq.pop_front();
                        chk("attr", 32'(attr_o), 32'(e.attr));
                        chk("bank", 32'(bank_o), 32'(e.bank));
                        chk("page", 32'(page_o), 32'(e.page));
`ifdef REGION_ATTR_SENDER_PARITY_EN
                        chk("par", 32'(attr_par_o), 32'(~^e.attr));
`endif
                        if (e.bank == 1'(NB - 1) && e.page == 6'(PPB - 1)) last_fired = 1;
                    end
                end
            end
        end
    end

    // Consumer ready: always, random, or a single 5-cycle stall on page 3
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                0: attr_ready_i = 1'b1;
                1: attr_ready_i = ($urandom_range(0, 3) != 0);
                default: begin
                    if (!stall_done && attr_valid_o && bank_o == 1'b0 && page_o == 6'd3) begin
                        attr_ready_i = 1'b0;
                        stall_done = 1;
                        cyc(5);
                        chk("stall_page_held", 32'(page_o), 32'(3));
                        attr_ready_i = 1'b1;
                        cyc(1);
                        chk("page_after_stall", 32'(page_o), 32'(4));
                    end else begin
                        attr_ready_i = 1'b1;
                    end
                end
            endcase
        end
    end

    initial begin
        int  n;
        bit  found;
        logic [3:0] ren;
        model_clear();
        rst_ni = 1'b0;
        cyc(3);
        chk_reset_vals();
        rst_ni = 1'b1;
        cyc(1);

        rdy_mode = 0;
        run_walk();

        cfg_write(0, 10, 4, PH_SEED, EN_TRUE);
        cfg_write(1, 0, 128, PH_RMA, EN_FALSE);
        run_walk();

        stall_done = 0;
        rdy_mode = 2;
        run_walk();
        chk("stall_exercised", 32'(stall_done), 32'(1));
        rdy_mode = 0;

        cfg_write(1, 0, 0, PH_RMA, EN_FALSE);
        cfg_write(2, 126, 10, PH_INV, EN_TRUE);
        run_walk();

        cfg_write(3, 20, 5, PH_SEED, 4'h3);
        run_walk();

        fork
            run_walk();
            begin
                cyc(12);
                cfg_write(0, 50, 20, PH_RMA, EN_TRUE);
            end
        join
        run_walk();

        drive_cfg(1, 90, 7, PH_INV, EN_FALSE);
        start_walk();
        cfg_we_i = 1'b0;
        chk("same_cycle_err", 32'(cfg_err_o), 32'(0));
        wait_done();

        rdy_mode = 1;
        repeat (4) begin
            repeat (3) begin
                ren = ($urandom_range(0, 2) == 0) ? 4'($urandom) :
                      ($urandom_range(0, 1) != 0 ? EN_TRUE : EN_FALSE);
                cfg_write($urandom_range(0, NR - 1), $urandom_range(0, TOT - 1),
                          $urandom_range(0, 200), 2'($urandom), ren);
            end
            run_walk();
        end

        rdy_mode = 0;
        start_walk();
        n = 0;
        found = 0;
        while (n < 500 && !found) begin
            @(negedge clk_i);
            if (attr_valid_o && page_o == 6'd40) found = 1;
            n++;
        end
        chk("reached_page40", 32'(found), 32'(1));
        #2;
        rst_ni = 1'b0;
        #1;
        chk_reset_vals();
        expq.delete();
        model_clear();
        walking = 1'b0;
        cyc(2);
        rst_ni = 1'b1;
        cyc(2);
        chk("no_done_after_reset", 32'(done_o), 32'(0));
        run_walk();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
